// File: rtl/lc_mem_pkg.sv
// Shared types and constants for the little_computer memory subsystem.
package lc_mem_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_DONE
    } arb_state_t;

    localparam int unsigned DRAM_ADDR_W = 25;  // 13 row + 10 col + 2 bank
    localparam int unsigned DRAM_DATA_W = 16;

    localparam int unsigned REQ_LOADER = 0;
    localparam int unsigned REQ_IFETCH = 1;
    localparam int unsigned REQ_DATA   = 2;

endpackage

// File: rtl/dram_arbiter_rr_pick.sv
// Combinational round-robin picker with optional absolute priority for port 0.
module rr_pick #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    input  logic             prio0,
    output logic             any,
    output logic [IDX_W-1:0] winner
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Search upward from last+1 with wrap; port 0 pre-empts when prio0 is set.
    always_comb begin
        any    = |req;
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        if (prio0 && req[0]) begin
            found = 1'b1;
        end
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IDX_W'((32'(last) + k) % N);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Arbitrates the single-transaction SDRAM controller port among NUM_REQ requesters.
module dram_arbiter
    import lc_mem_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = DRAM_ADDR_W,
    parameter int unsigned DATA_W  = DRAM_DATA_W,
    parameter int unsigned TIMEOUT = 1024,
    parameter bit          PRIO0   = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]         req_done,
    output logic [DATA_W-1:0]          req_rdata,
    input  logic                       ctrl_ready,
    output logic                       ctrl_cmd_valid,
    output logic                       ctrl_we,
    output logic [ADDR_W-1:0]          ctrl_addr,
    output logic [DATA_W-1:0]          ctrl_wdata,
    input  logic                       ctrl_done,
    input  logic [DATA_W-1:0]          ctrl_rdata,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       err_timeout
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    arb_state_t       state;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] winner;
    logic [CNT_W-1:0] wd_cnt;

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic             sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req_valid),
        .last   (last),
        .prio0  (PRIO0),
        .any    (pick_any),
        .winner (pick_idx)
    );

    // Select the picked port's command fields from the packed request buses.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Arbitration FSM; every output is a register updated on state transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ARB_IDLE;
            last           <= IDX_W'(NUM_REQ - 1);
            winner         <= '0;
            wd_cnt         <= '0;
            req_done       <= '0;
            req_rdata      <= '0;
            ctrl_cmd_valid <= 1'b0;
            ctrl_we        <= 1'b0;
            ctrl_addr      <= '0;
            ctrl_wdata     <= '0;
            busy           <= 1'b0;
            grant_id       <= '0;
            err_timeout    <= 1'b0;
        end else begin
            ctrl_cmd_valid <= 1'b0;
            req_done       <= '0;
            case (state)
                ARB_IDLE: begin
                    if (ctrl_ready && pick_any) begin
                        winner         <= pick_idx;
                        grant_id       <= pick_idx;
                        ctrl_we        <= sel_we;
                        ctrl_addr      <= sel_addr;
                        ctrl_wdata     <= sel_wdata;
                        ctrl_cmd_valid <= 1'b1;
                        busy           <= 1'b1;
                        state          <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    wd_cnt <= '0;
                    state  <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    if (ctrl_done) begin
                        req_rdata <= ctrl_rdata;
                        last      <= winner;
                        req_done  <= NUM_REQ'(1) << winner;
                        state     <= ARB_DONE;
                    end else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
                        req_rdata   <= '0;
                        err_timeout <= 1'b1;
                        req_done    <= NUM_REQ'(1) << winner;
                        state       <= ARB_DONE;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
                end
                ARB_DONE: begin
                    busy  <= 1'b0;
                    state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Randomized bench for dram_arbiter: a transaction-timeline model predicts every
// output each cycle; directed scenarios pin the model with literal expectations.
module tb_dram_arbiter;
    import lc_mem_pkg::*;

    localparam int N  = 3;
    localparam int AW = 25;
    localparam int DW = 16;
    localparam int TO = 16;
    localparam int IW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // Index 0: round-robin instance, index 1: port-0-priority instance.
    logic [N-1:0]    req_valid [2];
    logic [N-1:0]    req_we    [2];
    logic [N*AW-1:0] req_addr  [2];
    logic [N*DW-1:0] req_wdata [2];
    logic            ctrl_ready[2];
    logic            ctrl_done [2];
    logic [DW-1:0]   ctrl_rdata[2];
    logic [N-1:0]    req_done  [2];
    logic [DW-1:0]   req_rdata [2];
    logic            ctrl_cmd_valid[2];
    logic            ctrl_we   [2];
    logic [AW-1:0]   ctrl_addr [2];
    logic [DW-1:0]   ctrl_wdata[2];
    logic            busy      [2];
    logic [IW-1:0]   grant_id  [2];
    logic            err_timeout[2];

    dram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .PRIO0(1'b0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_done(req_done[0]), .req_rdata(req_rdata[0]), .ctrl_ready(ctrl_ready[0]),
        .ctrl_cmd_valid(ctrl_cmd_valid[0]), .ctrl_we(ctrl_we[0]), .ctrl_addr(ctrl_addr[0]),
        .ctrl_wdata(ctrl_wdata[0]), .ctrl_done(ctrl_done[0]), .ctrl_rdata(ctrl_rdata[0]),
        .busy(busy[0]), .grant_id(grant_id[0]), .err_timeout(err_timeout[0]));

    dram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .PRIO0(1'b1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_done(req_done[1]), .req_rdata(req_rdata[1]), .ctrl_ready(ctrl_ready[1]),
        .ctrl_cmd_valid(ctrl_cmd_valid[1]), .ctrl_we(ctrl_we[1]), .ctrl_addr(ctrl_addr[1]),
        .ctrl_wdata(ctrl_wdata[1]), .ctrl_done(ctrl_done[1]), .ctrl_rdata(ctrl_rdata[1]),
        .busy(busy[1]), .grant_id(grant_id[1]), .err_timeout(err_timeout[1]));

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Stimulus knobs
    bit          rst_cmd;
    int          lat_fix;
    bit          withhold;
    bit          rnd_to;
    bit          force_rd;
    logic [DW-1:0] rd_val;
    int          ready_mode;   // 0 high, 1 random, 2 low
    bit          hold_all;
    int          post_pct;

    // Requester and controller emulation
    bit            p_valid[2][N];
    bit            p_we   [2][N];
    logic [AW-1:0] p_addr [2][N];
    logic [DW-1:0] p_wdata[2][N];
    int            done_at[2];
    int            late_done_cyc[2];

    // Transaction timeline model: ISSUE cycle, DONE cycle, and visible register values.
    int            m_last [2];
    int            m_g    [2];
    int            m_end  [2];
    int            m_win  [2];
    int            m_grant[2];
    bit            m_err  [2];
    bit            m_we   [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_wdata[2];
    logic [DW-1:0] m_rdata[2];

    task automatic chk(input string nm, input int d, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s[dut%0d] cyc=%0d got=%0h expected=%0h", nm, d, cyc, got, exp);
    endtask

    function automatic bit m_busy(input int d, input int c);
        return (m_g[d] >= 0) && (c >= m_g[d]) && (m_end[d] < 0 || c <= m_end[d]);
    endfunction

    task automatic model_reset(input int d);
        m_last[d] = N - 1; m_g[d] = -1; m_end[d] = -1; m_win[d] = 0; m_grant[d] = 0;
        m_err[d] = 1'b0; m_we[d] = 1'b0; m_addr[d] = '0; m_wdata[d] = '0; m_rdata[d] = '0;
    endtask

    function automatic int pick(input int d);
        if (d == 1 && req_valid[d][0]) return 0;
        for (int k = 1; k <= N; k++) begin
            int p;
            p = (m_last[d] + k) % N;
            if (req_valid[d][IW'(p)]) return p;
        end
        return -1;
    endfunction

    // Advance the model with the inputs that the next rising edge will sample.
    task automatic model_step(input int d, input int c);
        int w;
        if (rst) begin
            model_reset(d);
        end else if (m_g[d] >= 0 && c > m_g[d] && m_end[d] < 0) begin
            if (ctrl_done[d]) begin
                m_end[d] = c + 1; m_rdata[d] = ctrl_rdata[d]; m_last[d] = m_win[d];
            end else if (c == m_g[d] + TO) begin
                m_end[d] = c + 1; m_rdata[d] = '0; m_err[d] = 1'b1;
            end
        end else if (!m_busy(d, c) && ctrl_ready[d]) begin
            w = pick(d);
            if (w >= 0) begin
                m_g[d] = c + 1; m_end[d] = -1; m_win[d] = w; m_grant[d] = w;
                m_we[d]    = req_we[d][IW'(w)];
                m_addr[d]  = req_addr[d][w*AW +: AW];
                m_wdata[d] = req_wdata[d][w*DW +: DW];
            end
        end
    endtask

    task automatic compare(input int d);
        int e_done;
        e_done = (m_end[d] >= 0 && m_end[d] == cyc) ? (1 << m_win[d]) : 0;
        chk("busy",       d, 64'(busy[d]),           64'(m_busy(d, cyc)));
        chk("cmd_valid",  d, 64'(ctrl_cmd_valid[d]), 64'(cyc == m_g[d]));
        chk("req_done",   d, 64'(req_done[d]),       64'(e_done));
        chk("ctrl_we",    d, 64'(ctrl_we[d]),        64'(m_we[d]));
        chk("ctrl_addr",  d, 64'(ctrl_addr[d]),      64'(m_addr[d]));
        chk("ctrl_wdata", d, 64'(ctrl_wdata[d]),     64'(m_wdata[d]));
        chk("req_rdata",  d, 64'(req_rdata[d]),      64'(m_rdata[d]));
        chk("grant_id",   d, 64'(grant_id[d]),       64'(m_grant[d]));
        chk("err_timeout",d, 64'(err_timeout[d]),    64'(m_err[d]));
    endtask

    task automatic post(input int d, input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        p_valid[d][p] = 1'b1; p_we[d][p] = we; p_addr[d][p] = a; p_wdata[d][p] = wd;
    endtask

    task automatic post_rand(input int d, input int p);
        post(d, p, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
    endtask

    task automatic drive(input int c);
        int lc[9];
        lc = '{1, 2, 3, 4, 5, 6, TO - 1, TO, TO + 1};
        rst = rst_cmd;
        for (int d = 0; d < 2; d++) begin
            if (rst_cmd) begin
                for (int p = 0; p < N; p++) p_valid[d][p] = 1'b0;
                done_at[d] = -1;
            end else begin
                if (m_g[d] == c) begin
                    if (withhold) done_at[d] = -1;
                    else if (lat_fix > 0) done_at[d] = c + lat_fix;
                    else if (rnd_to && $urandom_range(0, 24) == 0) done_at[d] = -1;
                    else done_at[d] = c + lc[$urandom_range(0, 8)];
                end
                if (m_end[d] == c) begin
                    p_valid[d][m_win[d]] = 1'b0;
                    if (hold_all) post_rand(d, m_win[d]);
                end
                for (int p = 0; p < N; p++)
                    if (!p_valid[d][p] && post_pct > 0 && $urandom_range(0, 99) < post_pct) post_rand(d, p);
            end
            ctrl_done[d]  = (c == done_at[d]) || (c == late_done_cyc[d]);
            ctrl_rdata[d] = force_rd ? rd_val : DW'($urandom);
            ctrl_ready[d] = (ready_mode == 2) ? 1'b0 : (ready_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            for (int p = 0; p < N; p++) begin
                req_valid[d][IW'(p)]    = p_valid[d][p];
                req_we[d][IW'(p)]       = p_we[d][p];
                req_addr[d][p*AW +: AW] = p_addr[d][p];
                req_wdata[d][p*DW +: DW] = p_wdata[d][p];
            end
        end
        for (int d = 0; d < 2; d++) model_step(d, c);
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) compare(d);
        drive(cyc);
    endtask

    task automatic do_reset();
        rst_cmd = 1'b1; tick(); tick(); rst_cmd = 1'b0;
    endtask

    int exp_rr[9];
    int k_rr[2];
    int c0;

    initial begin
        rst = 1'b1; rst_cmd = 1'b1; lat_fix = 0; withhold = 0; rnd_to = 0; force_rd = 0; rd_val = '0;
        ready_mode = 0; hold_all = 0; post_pct = 0;
        for (int d = 0; d < 2; d++) begin
            model_reset(d); done_at[d] = -1; late_done_cyc[d] = -1;
            ctrl_ready[d] = 1'b0; ctrl_done[d] = 1'b0; ctrl_rdata[d] = '0;
            req_valid[d] = '0; req_we[d] = '0; req_addr[d] = '0; req_wdata[d] = '0;
            for (int p = 0; p < N; p++) begin
                p_valid[d][p] = 0; p_we[d][p] = 0; p_addr[d][p] = '0; p_wdata[d][p] = '0;
            end
        end
        repeat (3) @(negedge clk);

        // Reset state
        do_reset();
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", d, 64'(busy[d]), 64'd0);
            chk("rst_grant", d, 64'(grant_id[d]), 64'd0);
            chk("rst_err", d, 64'(err_timeout[d]), 64'd0);
        end

        // Single read on the ifetch port
        lat_fix = 3; force_rd = 1; rd_val = 16'h4041;
        post(0, REQ_IFETCH, 1'b0, 25'h00005, 16'h0);
        tick(); c0 = cyc;
        tick();
        chk("t1_cmd", 0, 64'(ctrl_cmd_valid[0]), 64'd1);
        chk("t1_addr", 0, 64'(ctrl_addr[0]), 64'h5);
        repeat (3) tick();
        tick();
        chk("t1_done", 0, 64'(req_done[0]), 64'b010);
        chk("t1_rdata", 0, 64'(req_rdata[0]), 64'h4041);
        chk("t1_lat", 0, 64'(cyc - c0), 64'd5);
        tick();

        // Two ports together after reset
        do_reset();
        lat_fix = 1;
        post(0, REQ_IFETCH, 1'b0, 25'h100, 16'h0);
        post(0, REQ_DATA, 1'b1, 25'd31, 16'h6002);
        tick();
        tick();
        chk("t2_first", 0, 64'(grant_id[0]), 64'd1);
        repeat (3) tick();
        chk("t2_gap_idle", 0, 64'(busy[0]), 64'd0);
        tick();
        chk("t2_cmd", 0, 64'(ctrl_cmd_valid[0]), 64'd1);
        chk("t2_grant", 0, 64'(grant_id[0]), 64'd2);
        chk("t2_addr", 0, 64'(ctrl_addr[0]), 64'd31);
        chk("t2_wdata", 0, 64'(ctrl_wdata[0]), 64'h6002);
        chk("t2_we", 0, 64'(ctrl_we[0]), 64'd1);
        repeat (4) tick();

        // Continuous requests from all ports
        do_reset();
        lat_fix = 2; hold_all = 1; force_rd = 0;
        exp_rr = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
        for (int d = 0; d < 2; d++) begin
            k_rr[d] = 0;
            for (int p = 0; p < N; p++) post_rand(d, p);
        end
        for (int t = 0; t < 200 && !(k_rr[0] == 9 && k_rr[1] == 9); t++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                if (m_g[d] == cyc && k_rr[d] < 9) begin
                    chk("rr_order", d, 64'(grant_id[d]), 64'(d == 0 ? exp_rr[k_rr[d]] : 0));
                    chk("rr_model", d, 64'(m_win[d]), 64'(d == 0 ? exp_rr[k_rr[d]] : 0));
                    k_rr[d]++;
                end
            end
        end
        for (int d = 0; d < 2; d++) chk("rr_count", d, 64'(k_rr[d]), 64'd9);
        hold_all = 0;

        // ctrl_done on the last WAIT cycle beats the watchdog
        do_reset();
        lat_fix = TO; force_rd = 1; rd_val = 16'h1357;
        post(0, REQ_LOADER, 1'b0, 25'h1234, 16'h0);
        tick(); tick();
        repeat (16) tick();
        tick();
        chk("edge_done", 0, 64'(req_done[0]), 64'b001);
        chk("edge_err", 0, 64'(err_timeout[0]), 64'd0);
        chk("edge_rdata", 0, 64'(req_rdata[0]), 64'h1357);
        tick();

        // Watchdog abort
        withhold = 1;
        post(0, REQ_LOADER, 1'b0, 25'h1235, 16'h0);
        tick(); tick();
        repeat (16) tick();
        chk("to_pending", 0, 64'(req_done[0]), 64'd0);
        tick();
        chk("to_done", 0, 64'(req_done[0]), 64'b001);
        chk("to_rdata", 0, 64'(req_rdata[0]), 64'h0);
        chk("to_err", 0, 64'(err_timeout[0]), 64'd1);
        withhold = 0; lat_fix = 2; rd_val = 16'h2468;
        post(0, REQ_IFETCH, 1'b0, 25'h7, 16'h0);
        repeat (8) tick();
        chk("to_sticky", 0, 64'(err_timeout[0]), 64'd1);
        chk("to_next_rdata", 0, 64'(req_rdata[0]), 64'h2468);

        // Reset while waiting, then a late ctrl_done
        withhold = 1;
        post(0, REQ_DATA, 1'b0, 25'h42, 16'h0);
        repeat (4) tick();
        rst_cmd = 1'b1; late_done_cyc[0] = cyc + 2;
        tick();
        rst_cmd = 1'b0;
        tick();
        chk("rw_busy", 0, 64'(busy[0]), 64'd0);
        chk("rw_grant", 0, 64'(grant_id[0]), 64'd0);
        chk("rw_err", 0, 64'(err_timeout[0]), 64'd0);
        tick();
        chk("rw_nodone", 0, 64'(req_done[0]), 64'd0);
        withhold = 0;
        post(0, REQ_DATA, 1'b1, 25'h43, 16'hA5A5);
        tick(); tick();
        chk("rw_regrant", 0, 64'(grant_id[0]), 64'd2);
        repeat (6) tick();

        // ctrl_ready low holds the arbiter in IDLE
        ready_mode = 2;
        post(0, REQ_IFETCH, 1'b0, 25'h99, 16'h0);
        repeat (5) begin
            tick();
            chk("nr_cmd", 0, 64'(ctrl_cmd_valid[0]), 64'd0);
            chk("nr_busy", 0, 64'(busy[0]), 64'd0);
        end
        ready_mode = 0;
        tick();
        tick();
        chk("nr_issue", 0, 64'(ctrl_cmd_valid[0]), 64'd1);
        chk("nr_grant", 0, 64'(grant_id[0]), 64'd1);
        repeat (6) tick();

        // Randomized traffic with occasional resets
        force_rd = 0; lat_fix = 0; rnd_to = 1; ready_mode = 1; post_pct = 25;
        for (int t = 0; t < 4000; t++) begin
            rst_cmd = ($urandom_range(0, 599) == 0);
            tick();
        end
        rst_cmd = 1'b0; ready_mode = 0; post_pct = 0;
        repeat (60) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Shares the single-transaction SDRAM controller command port between up to NUM_REQ requesters: port 0 boot loader, port 1 CPU instruction fetch, port 2 CPU data load/store.
- Sits between the CPU/loader and the SDRAM controller inside little_computer.
- Uses round-robin arbitration, with optional absolute priority for port 0.
- Allows one outstanding transaction, and has a watchdog timeout with a sticky error flag.

Parameters:
- NUM_REQ, 3, number of requester ports (2..8).
- ADDR_W, 25, word address width (13 row + 10 col + 2 bank).
- DATA_W, 16, data word width.
- TIMEOUT, 1024, maximum cycles in WAIT before abort.
- PRIO0, 0, 1 = port 0 always wins when requesting.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-port request; held until that port's req_done.
- req_we  in  NUM_REQ  per-port 1 = write.
- req_addr  in  NUM_REQ*ADDR_W  per-port address, packed, port i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  per-port write data, packed.
- req_done  out  NUM_REQ  one-hot one-cycle completion pulse.
- req_rdata  out  DATA_W  read data shared by all ports, valid with req_done.
- ctrl_ready  in  1  controller idle and able to accept a command.
- ctrl_cmd_valid  out  1  one-cycle command strobe.
- ctrl_we  out  1  command is a write.
- ctrl_addr  out  ADDR_W  command address.
- ctrl_wdata  out  DATA_W  command write data.
- ctrl_done  in  1  one-cycle pulse when the transaction completes.
- ctrl_rdata  in  DATA_W  read data, valid with ctrl_done.
- busy  out  1  state != IDLE.
- grant_id  out  $clog2(NUM_REQ)  port currently or last served.
- err_timeout  out  1  sticky; set when a transaction is aborted.

Behaviour:

Reset:
- State is IDLE.
- All outputs are 0.
- The last-granted pointer is NUM_REQ-1, so port 0 wins the first round-robin tie.
- Reset mid-transaction abandons the transaction. No req_done is issued for it. A late ctrl_done arriving in IDLE is ignored.

IDLE:
- If ctrl_ready and req_valid != 0, pick a winner:
  - PRIO0=1 and req_valid[0]: winner is port 0.
  - Otherwise: first set bit searching upward from last+1, wrapping modulo NUM_REQ.
- Latch winner index, we, addr and wdata into internal registers, update grant_id, go to ISSUE.
- If ctrl_ready is low, stay in IDLE.

ISSUE:
- ctrl_cmd_valid=1 for exactly this cycle.
- ctrl_we, ctrl_addr and ctrl_wdata are driven from the latched registers. They hold their values until the next ISSUE.
- Clear the watchdog counter, go to WAIT.

WAIT:
- Counter increments each cycle.
- On ctrl_done: register ctrl_rdata into req_rdata, set last=winner, go to DONE.
- If the counter reaches TIMEOUT-1 without ctrl_done: set err_timeout, force req_rdata=0, go to DONE.
- If ctrl_done and timeout coincide, ctrl_done wins and err_timeout is not set.

DONE:
- req_done[winner]=1 for this cycle only, then go to IDLE.
- No arbitration happens in DONE. A requester must drop req_valid (or present a new request) by the cycle after req_done.

Latency and data rules:
- Minimum latency is request seen in IDLE at cycle 0 -> ctrl_cmd_valid at cycle 1.
- ctrl_done at cycle k -> req_done at cycle k+1.
- req_rdata holds its value until the next DONE.
- err_timeout is cleared only by rst.
- Requests from non-winning ports stay pending; nothing is dropped or reordered within a port.
- Write transactions also return through ctrl_done; req_rdata is undefined-but-stable for writes and is passed through from ctrl_rdata.

Decomposition:
- Package lc_mem_pkg holds:
  - typedef enum arb_state_t {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DONE};
  - localparams DRAM_ADDR_W=25, DRAM_DATA_W=16;
  - requester index constants REQ_LOADER=0, REQ_IFETCH=1, REQ_DATA=2.
- One sub-module: rr_pick, a combinational round-robin picker.
  - Inputs: req vector, last index, prio0 enable.
  - Outputs: any, winner index.
  - Reusable for a future VGA/DMA port.

Test Plan:
1. Single read, port 1, addr 0x00005, controller returns 0x4041 three cycles after the command -> ctrl_cmd_valid one cycle after the request, ctrl_addr=0x00005, req_done=3'b010 one cycle after ctrl_done, req_rdata=0x4041.
2. Ports 1 and 2 request together after reset -> port 1 is served first (pointer starts at 2, so the search begins at 0 and the next set bit is 1), then port 2, with no idle gap beyond DONE->IDLE->ISSUE. The port 2 write of 0x6002 to addr 31 appears on ctrl_wdata/ctrl_addr.
3. All three ports hold requests continuously for 9 transactions -> grant order is 0,1,2,0,1,2,0,1,2 with PRIO0=0. With PRIO0=1 and port 0 always requesting, port 0 wins every grant.
4. ctrl_done withheld, TIMEOUT=16 -> after 16 WAIT cycles req_done pulses for the winner, req_rdata=0 and err_timeout=1. err_timeout stays 1 through later successful transactions until rst.
5. rst asserted for 1 cycle while in WAIT, then a late ctrl_done -> busy=0, no req_done, grant_id=0, err_timeout=0. A following request from port 2 is granted normally.
6. ctrl_ready low while requests are pending -> arbiter stays in IDLE with ctrl_cmd_valid=0. ISSUE occurs on the cycle after ctrl_ready rises.
